// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM states,
// default operand width and the quotient returned on divide-by-zero.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // Divide-by-zero quotient. All ones, so sign-extending it gives all ones at any width.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes.
// {R,Q} is shifted left by one. The shifted R is compared against D,
// and the result bit enters Q[0].
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shifted remainder carries one extra bit so the trial subtraction sign is exact.
  // When the trial is negative the shifted value is below D, so it fits in WIDTH bits.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, div_i};
    rem_o   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule : div_step

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed divider sequencer with a start/busy/done handshake.
// Operands are converted to magnitudes, divided by an iterative restoring
// step, then sign-corrected. The result truncates toward zero, and the
// remainder takes the dividend's sign.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_QUO = WIDTH'($signed(DIV_ZERO_QUO));

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;        // captured dividend
  logic [WIDTH-1:0] b_q, b_d;        // captured divisor
  logic             sign_a_q, sign_a_d;
  logic             neg_q_q, neg_q_d; // quotient sign = sign_a ^ sign_b
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // magnitude dividend shifting into quotient
  logic [WIDTH-1:0] d_q, d_d;        // divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;

  // Magnitude of a two's-complement value.
  // The most negative value maps to 2^(WIDTH-1) as an unsigned number.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (r_q),
    .quo_i (q_q),
    .div_i (d_q),
    .rem_o (step_r),
    .quo_o (step_q)
  );

  // State and datapath registers. Clear aborts any operation in flight.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      neg_q_q  <= 1'b0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      neg_q_q  <= neg_q_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state and datapath updates. Results move only on entry to DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    neg_q_d  = neg_q_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dz_d     = dz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = SETUP;
          a_d      = dividend_i;
          b_d      = divisor_i;
          sign_a_d = dividend_i[WIDTH-1];
          neg_q_d  = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (b_q == '0) begin
          state_d = DONE;
          quo_d   = ZERO_QUO;
          rem_d   = a_q;
          dz_d    = 1'b1;
        end else begin
          state_d = ITER;
          r_d     = '0;
          q_d     = abs_val(a_q);
          d_d     = abs_val(b_q);
          cnt_d   = '0;
        end
      end
      ITER: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        state_d = DONE;
        quo_d   = neg_q_q ? -q_q : q_q;
        rem_d   = sign_a_q ? -r_q : r_q;
        dz_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q == SETUP) || (state_q == ITER) || (state_q == FIXUP);
  assign done_o      = (state_q == DONE);
  assign div_zero_o  = dz_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule : div_seq_ctrl

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl.
// It runs directed corner cases plus randomized operands against a
// wide-integer arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         clear;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_vec = 0;
  int n_err = 0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clock_i     (clk),
    .clear_i     (clear),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .busy_o      (busy),
    .done_o      (done),
    .div_zero_o  (div_zero),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed 64-bit arithmetic.
  // Division and remainder truncate toward zero, and results are truncated to W bits.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    longint sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
      dz = 1'b0;
    end
  endfunction

  // One division.
  // repulse: re-assert start with other operands at cycles 5 and 20.
  // hold:    return inside the DONE cycle so the caller can issue back-to-back.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input bit repulse, input bit hold);
    logic [W-1:0] eq, er;
    logic         edz;
    int           lat;
    bit           busy_bad;
    ref_div(a, b, eq, er, edz);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 0;
    busy_bad = 1'b0;
    while (!done && lat < 100) begin
      if (!busy) busy_bad = 1'b1;
      if (repulse && (lat == 5 || lat == 20)) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom_range(1, 9);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("latency", 64'(lat), edz ? 64'd1 : 64'(W + 2));
    chk("busy_during_op", 64'(busy_bad), 64'd0);
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("quotient", 64'(quotient), 64'(eq));
    chk("remainder", 64'(remainder), 64'(er));
    chk("div_zero", 64'(div_zero), 64'(edz));
    $display("op %08h / %08h -> q=%08h r=%08h dz=%0d lat=%0d", a, b, quotient, remainder,
             div_zero, lat);
    if (!hold) begin
      @(posedge clk); #1;
      chk("done_pulse", 64'(done), 64'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int           mode;
    bit           done_seen;

    clear    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    chk("rst_quo", 64'(quotient), 64'd0);
    chk("rst_rem", 64'(remainder), 64'd0);
    @(negedge clk);
    clear = 1'b0;

    // Directed cases
    op(32'd250, 32'd25, 0, 0);
    op(-32'sd100, 32'd30, 0, 0);
    op(32'd100, -32'sd30, 0, 0);
    op(32'd12345, 32'd0, 0, 0);
    op(32'd5, 32'd10, 0, 0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    op(32'h0800_0000, 32'h0080_0000, 0, 0);
    op(32'd1000000, 32'd777, 1, 0);           // re-pulsed start ignored
    op(32'd999, 32'd4, 0, 1);                 // start held in DONE ...
    op(-32'sd77777, 32'd13, 0, 0);            // ... accepted back-to-back
    op(32'd7, 32'd0, 0, 1);                   // back-to-back after div-by-zero
    op(-32'sd100, 32'd30, 0, 0);              // leaves nonzero results

    // Asynchronous clear in the middle of the iterations
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    clear = 1'b1;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_dz", 64'(div_zero), 64'd0);
    chk("clr_quo", 64'(quotient), 64'd0);
    chk("clr_rem", 64'(remainder), 64'd0);
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    @(negedge clk);
    clear = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen = 1'b1;
    end
    chk("no_done_after_clear", 64'(done_seen), 64'd0);
    op(32'd1000, 32'd7, 0, 0);

    // Randomized operands, biased toward zero and small divisors
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      mode = $urandom_range(0, 4);
      case (mode)
        0:       rb = '0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = -($urandom_range(1, 20));
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      op(ra, rb, 1'b0, bit'($urandom_range(0, 3) == 0));
    end
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_div_seq_ctrl
